// File: rtl/countdown_sequencer.sv
// Initiator for the 1 Hz countdown timer: loads per-stage durations, waits for the
// timer's done flag and reports stage/sequence completion, optionally chaining stages up to 3.
module countdown_sequencer #(
   parameter int STAGE0_SEC = 300,
   parameter int STAGE1_SEC = 420,
   parameter int STAGE2_SEC = 480,
   parameter int STAGE3_SEC = 0
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [1:0] i_stage_sel,
   input  logic       i_chain,
   input  logic       i_abort,
   output logic       o_timer_reset,
   output logic [9:0] o_timer_seconds,
   input  logic       i_timer_signal,
   output logic       o_busy,
   output logic [1:0] o_active_stage,
   output logic       o_stage_done,
   output logic       o_seq_done,
   output logic [9:0] o_elapsed
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

   state_t     r_state,         w_state;
   logic       r_chain,         w_chain;
   logic       r_timer_reset,   w_timer_reset;
   logic [9:0] r_timer_seconds, w_timer_seconds;
   logic       r_busy,          w_busy;
   logic [1:0] r_stage,         w_stage;
   logic       r_stage_done,    w_stage_done;
   logic       r_seq_done,      w_seq_done;
   logic [9:0] r_elapsed,       w_elapsed;
   logic [1:0] w_next_stage;

   function automatic logic [9:0] f_dur(input logic [1:0] s);
      case (s)
         2'd0:    f_dur = 10'(STAGE0_SEC);
         2'd1:    f_dur = 10'(STAGE1_SEC);
         2'd2:    f_dur = 10'(STAGE2_SEC);
         default: f_dur = 10'(STAGE3_SEC);
      endcase
   endfunction

   assign w_next_stage = r_stage + 2'd1;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state         <= S_IDLE;
         r_chain         <= 1'b0;
         r_timer_reset   <= 1'b1;
         r_timer_seconds <= '0;
         r_busy          <= 1'b0;
         r_stage         <= '0;
         r_stage_done    <= 1'b0;
         r_seq_done      <= 1'b0;
         r_elapsed       <= '0;
      end else begin
         r_state         <= w_state;
         r_chain         <= w_chain;
         r_timer_reset   <= w_timer_reset;
         r_timer_seconds <= w_timer_seconds;
         r_busy          <= w_busy;
         r_stage         <= w_stage;
         r_stage_done    <= w_stage_done;
         r_seq_done      <= w_seq_done;
         r_elapsed       <= w_elapsed;
      end
   end

   always_comb begin
      w_state         = r_state;
      w_chain         = r_chain;
      w_timer_reset   = r_timer_reset;
      w_timer_seconds = r_timer_seconds;
      w_busy          = r_busy;
      w_stage         = r_stage;
      w_stage_done    = 1'b0;
      w_seq_done      = 1'b0;
      w_elapsed       = r_elapsed;
      case (r_state)
         S_IDLE: begin
            w_timer_reset = 1'b0;
            if (i_start) begin
               w_stage         = i_stage_sel;
               w_chain         = i_chain;
               w_timer_seconds = f_dur(i_stage_sel);
               w_timer_reset   = 1'b1;
               w_busy          = 1'b1;
               w_state         = S_LOAD;
            end
         end
         // timer_signal may still be a stale 1 here, so LOAD never looks at it
         S_LOAD: begin
            if (i_abort) begin
               w_state         = S_IDLE;
               w_timer_reset   = 1'b1;
               w_timer_seconds = '0;
               w_busy          = 1'b0;
            end else begin
               w_timer_reset = 1'b0;
               w_elapsed     = '0;
               w_state       = S_RUN;
            end
         end
         S_RUN: begin
            if (i_abort) begin
               w_state         = S_IDLE;
               w_timer_reset   = 1'b1;
               w_timer_seconds = '0;
               w_busy          = 1'b0;
            end else if (i_timer_signal) begin
               w_stage_done = 1'b1;
               if (r_chain && (r_stage != 2'd3)) begin
                  w_stage         = w_next_stage;
                  w_timer_seconds = f_dur(w_next_stage);
                  w_timer_reset   = 1'b1;
                  w_state         = S_LOAD;
               end else begin
                  w_seq_done = 1'b1;
                  w_busy     = 1'b0;
                  w_state    = S_IDLE;
               end
            end else if (r_elapsed != 10'd1023) begin
               w_elapsed = r_elapsed + 10'd1;
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   assign o_timer_reset   = r_timer_reset;
   assign o_timer_seconds = r_timer_seconds;
   assign o_busy          = r_busy;
   assign o_active_stage  = r_stage;
   assign o_stage_done    = r_stage_done;
   assign o_seq_done      = r_seq_done;
   assign o_elapsed       = r_elapsed;

endmodule
